// File: rtl/muldiv_pkg.sv
// Shared constants and types for the muldiv_sequencer block.
// Optional feature macro: MULDIV_SIGNED_EN (signed MULS/DIVS support).
package muldiv_pkg;

  // Operation codes carried on func (low four bits).
  localparam logic [3:0] FUNC_MUL  = 4'b1010;
  localparam logic [3:0] FUNC_DIV  = 4'b1011;
  localparam logic [3:0] FUNC_MULS = 4'b1100;
  localparam logic [3:0] FUNC_DIVS = 4'b1101;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Bit positions inside the 3-bit flag output.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the Execute stage and muldiv_sequencer.
//
// Handshake: start is a single-cycle request qualifier with no ready wire.
// A request is accepted exactly when the sequencer is idle and func is a
// supported code; acceptance is visible the same cycle as stall=1. Requests
// made while busy, or with unsupported codes, are dropped (no queuing).
// done is a one-cycle valid for resultLo/resultHi/flag with no back-pressure;
// the result values then hold until the next operation completes.
interface muldiv_sequencer_if #(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 4
);
  logic              start;
  logic [FUNC_W-1:0] func;
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic              stall;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  resultLo;
  logic [WIDTH-1:0]  resultHi;
  logic [2:0]        flag;

  modport master (
    output start, func, opA, opB,
    input  stall, busy, done, resultLo, resultHi, flag
  );

  modport slave (
    input  start, func, opA, opB,
    output stall, busy, done, resultLo, resultHi, flag
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath. The 2*WIDTH+1 accumulator holds
// {carry/upper, lower}: for MUL the lower half is the multiplier being
// shifted out LSB first; for DIV the upper WIDTH+1 bits are the partial
// remainder and the lower half is the dividend turning into the quotient.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_out
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           ge;

  // Conditional add-and-shift (MUL) or trial subtract-and-shift (DIV).
  always_comb begin
    add_sum = acc_in[2*WIDTH:WIDTH] + {1'b0, operand};
    shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    ge      = (shifted >= {1'b0, operand});
    trial   = shifted - {1'b0, operand};
    if (is_div) begin
      acc_out = {(ge ? trial : shifted), acc_in[WIDTH-2:0], ge};
    end else begin
      acc_out = {1'b0, (acc_in[0] ? add_sum : acc_in[2*WIDTH:WIDTH]),
                 acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer: one bit per cycle through a shared
// shift/add/subtract step, stalling the pipeline while it iterates.
// Optional feature macro: MULDIV_SIGNED_EN adds MULS/DIVS by converting
// operands to magnitudes at latch time and fixing the sign on entry to DONE.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   bus,
  output state_t              dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [2:0]         flag_q, flag_d;
`ifdef MULDIV_SIGNED_EN
  logic               neg_p_q, neg_p_d;   // negate product / quotient
  logic               neg_r_q, neg_r_d;   // negate remainder
  logic               op_signed, a_neg, b_neg;
`endif

  logic               is_mul_req, is_div_req, req_ok;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH:0]   step_out;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               fin_load, fin_div, fin_dz;
  logic [WIDTH-1:0]   fin_lo, fin_hi;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (state_q == ST_DIV),
    .acc_in  (acc_q),
    .operand (opr_q),
    .acc_out (step_out)
  );

  // Decode the request and form operand magnitudes.
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    op_signed  = (bus.func == FUNC_W'(FUNC_MULS)) | (bus.func == FUNC_W'(FUNC_DIVS));
    is_mul_req = (bus.func == FUNC_W'(FUNC_MUL))  | (bus.func == FUNC_W'(FUNC_MULS));
    is_div_req = (bus.func == FUNC_W'(FUNC_DIV))  | (bus.func == FUNC_W'(FUNC_DIVS));
    a_neg      = op_signed & bus.opA[WIDTH-1];
    b_neg      = op_signed & bus.opB[WIDTH-1];
    a_mag      = a_neg ? -bus.opA : bus.opA;
    b_mag      = b_neg ? -bus.opB : bus.opB;
`else
    is_mul_req = (bus.func == FUNC_W'(FUNC_MUL));
    is_div_req = (bus.func == FUNC_W'(FUNC_DIV));
    a_mag      = bus.opA;
    b_mag      = bus.opB;
`endif
    req_ok = bus.start & (is_mul_req | is_div_req);
  end

  // Next-state, datapath sequencing and result capture on entry to DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opr_d    = opr_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_d   = flag_q;
`ifdef MULDIV_SIGNED_EN
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
`endif
    prod     = '0;
    quo      = '0;
    rem      = '0;
    fin_load = 1'b0;
    fin_div  = 1'b0;
    fin_dz   = 1'b0;
    fin_lo   = '0;
    fin_hi   = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          cnt_d = '0;
`ifdef MULDIV_SIGNED_EN
          neg_p_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
`endif
          if (is_mul_req) begin
            state_d = ST_MUL;
            acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
            opr_d   = a_mag;
          end else if (bus.opB == '0) begin
            // Divide by zero skips iteration; raw dividend is reported.
            state_d  = ST_DONE;
            fin_load = 1'b1;
            fin_div  = 1'b1;
            fin_dz   = 1'b1;
            fin_lo   = '1;
            fin_hi   = bus.opA;
          end else begin
            state_d = ST_DIV;
            acc_d   = {{(WIDTH+1){1'b0}}, a_mag};
            opr_d   = b_mag;
          end
        end
      end
      ST_MUL: begin
        acc_d = step_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = ST_DONE;
          fin_load = 1'b1;
          prod     = step_out[2*WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
          if (neg_p_q) prod = -prod;
`endif
          fin_lo = prod[WIDTH-1:0];
          fin_hi = prod[2*WIDTH-1:WIDTH];
        end
      end
      ST_DIV: begin
        acc_d = step_out;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d  = ST_DONE;
          fin_load = 1'b1;
          fin_div  = 1'b1;
          quo      = step_out[WIDTH-1:0];
          rem      = step_out[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
          if (neg_p_q) quo = -quo;
          if (neg_r_q) rem = -rem;
`endif
          fin_lo = quo;
          fin_hi = rem;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin_load) begin
      res_lo_d       = fin_lo;
      res_hi_d       = fin_hi;
      flag_d[FLAG_Z] = ({fin_hi, fin_lo} == '0);
      flag_d[FLAG_N] = fin_div ? fin_lo[WIDTH-1] : fin_hi[WIDTH-1];
      flag_d[FLAG_C] = fin_div ? fin_dz : (fin_hi != '0);
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      opr_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_q   <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_q   <= flag_d;
`ifdef MULDIV_SIGNED_EN
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
`endif
    end
  end

  assign bus.stall    = ((state_q == ST_IDLE) & req_ok) |
                        (state_q == ST_MUL) | (state_q == ST_DIV);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.resultLo = res_lo_q;
  assign bus.resultHi = res_hi_q;
  assign bus.flag     = flag_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide controller for the Execute stage. It accepts a MUL or DIV request alongside the ALU's `func` code, owns a shared one-bit-per-cycle shift/add/subtract datapath, and stalls the pipeline while iterating. It returns a 2×WIDTH result plus the 3-bit flags that the Execute flag register latches.

## Interface
- `WIDTH`, default 16: operand width in bits.
- `FUNC_W`, default 4: width of the `func` code.
- `clk  in  1`: single clock; all state on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: request qualifier, sampled together with `func`.
- `func  in  FUNC_W`: operation code.
  - 4'b1010 MUL, 4'b1011 DIV.
  - 4'b1100 MULS, 4'b1101 DIVS (signed; require `MULDIV_SIGNED_EN`).
- `opA  in  WIDTH`: multiplicand or dividend.
- `opB  in  WIDTH`: multiplier or divisor.
- `stall  out  1`: freezes the upstream pipeline stages.
- `busy  out  1`: high while the FSM is not IDLE.
- `done  out  1`: one-cycle pulse marking the result as valid.
- `resultLo  out  WIDTH`: product low half, or quotient.
- `resultHi  out  WIDTH`: product high half, or remainder.
- `flag  out  3`: [0]=Z, [1]=N, [2]=C.

## Operation
- **FSM states:** IDLE, MUL, DIV, DONE.
- **IDLE:**
  - `start` with a supported `func` latches `opA`/`opB`, clears the iteration counter, and moves to MUL or DIV.
  - DIV with `opB==0` goes straight to DONE.
  - `start` with any other `func` is ignored.
- **MUL (unsigned shift-add):**
  - One multiplier bit per cycle, LSB first.
  - Accumulator is 2×WIDTH+1 bits so the carry is kept.
  - Runs for WIDTH cycles, then moves to DONE.
- **DIV (restoring division):**
  - One quotient bit per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits.
  - Runs for WIDTH cycles, then moves to DONE.
- **Divide by zero:**
  - `resultLo` = all ones, `resultHi` = dividend, C=1.
  - No iterations are performed.
- **DONE:**
  - Lasts exactly one cycle with `done`=1.
  - `resultLo`, `resultHi` and `flag` are registered on entry to DONE.
  - The FSM always moves to IDLE next.
- **Flags** (updated only on entry to DONE; held otherwise):
  - Z = ({resultHi,resultLo}==0).
  - N = MSB of `resultHi` for MUL, MSB of `resultLo` for DIV.
  - C = (`resultHi`!=0) for MUL; divide-by-zero for DIV.
- **Result hold:** results stay stable from DONE until the next accepted `start`. IDLE does not clear them.
- **Busy:** `start` while the FSM is not IDLE is ignored; no queuing.
- **Reset:**
  - Immediately forces IDLE and zeroes all outputs.
  - An operation in flight is aborted without a `done` pulse.

## Timing
- The `start` cycle is cycle 0.
- `stall` is combinational: `(state==IDLE & start & supported func) | state==MUL | state==DIV`.
  - This gives stall=1 in cycles 0..WIDTH.
  - stall=0 in the DONE cycle, so the pipeline advances while the result is captured.
- `done` goes high in cycle WIDTH+1 (17 at default). For divide by zero it goes high in cycle 1.
- `busy` is registered: high in cycles 1..WIDTH+1.
- Earliest next accepted `start` is cycle WIDTH+2.
- Reset value of every output is 0.

## Configuration
- **`MULDIV_SIGNED_EN` defined:**
  - MULS and DIVS are supported.
  - Operands are converted to magnitude at latch time and the unsigned core is reused.
  - The result sign is fixed up on entry to DONE, with no extra cycle.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Signed divide by zero gives the same result as unsigned.
- **Undefined:**
  - 4'b1100 and 4'b1101 are unsupported: no stall and no state change.
  - The sign-correction logic is absent.

## Structure
- **Package `muldiv_pkg`:**
  - `func` code localparams.
  - FSM state typedef.
  - Flag bit indices (FLAG_Z, FLAG_N, FLAG_C).
- **Sub-module `muldiv_step`:**
  - Combinational single-iteration unit.
  - Performs a conditional add-and-shift for MUL, or a trial subtract-and-shift for DIV.
  - Instantiated once and driven by the FSM.

## Test plan
- **MUL:** 0x1234 × 0x0010 → `resultHi`=0x0001, `resultLo`=0x2340, C=1, Z=0; `done` in cycle 17 only; stall high in cycles 0–16.
- **DIV:** 100 ÷ 7 → `resultLo`=14, `resultHi`=2, flags 3'b000; `done` in cycle 17.
- **Divide by zero:** 0x00FF ÷ 0 → `resultLo`=0xFFFF, `resultHi`=0x00FF, C=1; `done` in cycle 1.
- **Busy and reset:**
  - A second `start` at cycle 5 is ignored; the first result is unaltered.
  - `rst` pulsed at cycle 8 → all outputs 0 and no `done`.
  - A following MUL 3×5 gives `resultLo`=15.
- **Signed (macro on):**
  - MULS 0xFFFE×3 → {`resultHi`,`resultLo`}=0xFFFF_FFFA, N=1.
  - DIVS −7÷2 → `resultLo`=0xFFFD, `resultHi`=0xFFFF.
- **Signed (macro off):** `func`=4'b1100 with `start` → `stall`=0, `busy`=0, no `done`.
